mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared bus definitions for the two-master memory arbiter: FSM state encoding,
// master index constants and the timeout counter width.
package mem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  localparam logic MST0  = 1'b0;
  localparam logic MST1  = 1'b1;
  localparam int   CNT_W = 8;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single memory slave, with a
// slave response timeout that completes the transaction with ERR_DATA.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_dout,
  input  logic        m0_wr,
  input  logic [3:0]  m0_lane,
  input  logic        m0_valid,
  output logic [31:0] m0_din,
  output logic        m0_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_dout,
  input  logic        m1_wr,
  input  logic [3:0]  m1_lane,
  input  logic        m1_valid,
  output logic [31:0] m1_din,
  output logic        m1_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_dout,
  output logic        s_wr,
  output logic [3:0]  s_lane,
  output logic        s_valid,
  input  logic [31:0] s_din,
  input  logic        s_ready,
  output logic        grant,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic gnt_valid;
  logic s_done;
  logic s_tmo;
  logic pick;

  // A live transaction needs the owner to keep its request up; s_ready beats timeout.
  assign gnt_valid = (state_q == ST_BUSY) && (grant_q ? m1_valid : m0_valid);
  assign s_done    = gnt_valid && s_ready;
  assign s_tmo     = gnt_valid && !s_ready && (cnt_q == CNT_LAST);
  assign pick      = (m0_valid && m1_valid) ? ~last_q : m1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= MST0;
      last_q  <= MST1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d = ST_BUSY;
          grant_d = pick;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        // grant_q returns to master 0 so the idle slave port mirrors master 0.
        if (!gnt_valid) begin
          state_d = ST_IDLE;
          grant_d = MST0;
        end else if (s_done || s_tmo) begin
          state_d = ST_IDLE;
          grant_d = MST0;
          last_d  = grant_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == ST_BUSY);
    grant       = grant_q;
    s_valid     = gnt_valid;
    s_addr      = grant_q ? m1_addr : m0_addr;
    s_dout      = grant_q ? m1_dout : m0_dout;
    s_wr        = grant_q ? m1_wr   : m0_wr;
    s_lane      = grant_q ? m1_lane : m0_lane;
    m0_ready    = (s_done || s_tmo) && (grant_q == MST0);
    m1_ready    = (s_done || s_tmo) && (grant_q == MST1);
    m0_din      = (s_tmo && (grant_q == MST0)) ? ERR_DATA : s_din;
    m1_din      = (s_tmo && (grant_q == MST1)) ? ERR_DATA : s_din;
    timeout_err = s_tmo;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all checked
// each cycle against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int          TMO = 16;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] ma[2];
  logic [31:0] md[2];
  logic        mw[2];
  logic [3:0]  ml[2];
  logic        mv[2];
  logic [31:0] m0_din, m1_din, s_addr, s_dout, s_din;
  logic        m0_ready, m1_ready, s_wr, s_valid, s_ready, grant, busy, timeout_err;
  logic [3:0]  s_lane;

  int total = 0;
  int bad   = 0;

  // Model: is a transaction open, who owns it, who was served last, 1-based cycle in it.
  bit busy_m;
  bit own;
  bit last_m;
  int cyc;
  bit e_rdy[2];

  logic        o_busy, o_grant, o_svalid, o_rdy0, o_rdy1, o_tmo, o_swr;
  logic [31:0] o_din0, o_saddr, o_sdout;
  logic [3:0]  o_slane;

  mem_arbiter #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(ma[0]), .m0_dout(md[0]), .m0_wr(mw[0]), .m0_lane(ml[0]), .m0_valid(mv[0]),
    .m0_din(m0_din), .m0_ready(m0_ready),
    .m1_addr(ma[1]), .m1_dout(md[1]), .m1_wr(mw[1]), .m1_lane(ml[1]), .m1_valid(mv[1]),
    .m1_din(m1_din), .m1_ready(m1_ready),
    .s_addr(s_addr), .s_dout(s_dout), .s_wr(s_wr), .s_lane(s_lane), .s_valid(s_valid),
    .s_din(s_din), .s_ready(s_ready),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic new_req(input int i);
    ma[i] = $urandom;
    md[i] = $urandom;
    mw[i] = 1'($urandom);
    ml[i] = 4'($urandom);
    mv[i] = 1'b1;
  endtask

  // Called at a falling edge with inputs applied; checks, advances the model, returns at next falling edge.
  task automatic tick();
    logic sel, gv, done, to;
    #1;
    sel  = busy_m ? own : 1'b0;
    gv   = busy_m && mv[own];
    done = gv && s_ready;
    to   = gv && !s_ready && (cyc == TMO);
    e_rdy[0] = gv && !own && (done || to);
    e_rdy[1] = gv &&  own && (done || to);
    chk("busy",    32'(busy),        32'(busy_m));
    chk("grant",   32'(grant),       32'(busy_m ? own : 1'b0));
    chk("s_valid", 32'(s_valid),     32'(gv));
    chk("s_addr",  s_addr,           ma[sel]);
    chk("s_dout",  s_dout,           md[sel]);
    chk("s_wr",    32'(s_wr),        32'(mw[sel]));
    chk("s_lane",  32'(s_lane),      32'(ml[sel]));
    chk("m0_rdy",  32'(m0_ready),    32'(e_rdy[0]));
    chk("m1_rdy",  32'(m1_ready),    32'(e_rdy[1]));
    chk("m0_din",  m0_din,           (e_rdy[0] && to) ? ERR : s_din);
    chk("m1_din",  m1_din,           (e_rdy[1] && to) ? ERR : s_din);
    chk("tmo_err", 32'(timeout_err), 32'(to));
    o_busy = busy; o_grant = grant; o_svalid = s_valid; o_rdy0 = m0_ready; o_rdy1 = m1_ready;
    o_tmo = timeout_err; o_din0 = m0_din; o_saddr = s_addr; o_sdout = s_dout; o_swr = s_wr;
    o_slane = s_lane;
    if (!busy_m) begin
      if (mv[0] || mv[1]) begin
        busy_m = 1'b1;
        own    = (mv[0] && mv[1]) ? !last_m : mv[1];
        cyc    = 1;
      end
    end else if (!gv) begin
      busy_m = 1'b0;
    end else if (done || to) begin
      busy_m = 1'b0;
      last_m = own;
    end else begin
      cyc++;
    end
    @(negedge clk);
  endtask

  // Called at a falling edge; asserts reset between clock edges and checks outputs at once.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy",  32'(busy),        0);
    chk("rst_sval",  32'(s_valid),     0);
    chk("rst_grant", 32'(grant),       0);
    chk("rst_rdy0",  32'(m0_ready),    0);
    chk("rst_rdy1",  32'(m1_ready),    0);
    chk("rst_tmo",   32'(timeout_err), 0);
    busy_m = 1'b0; own = 1'b0; last_m = 1'b1; cyc = 0;
    e_rdy[0] = 1'b0; e_rdy[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int sv, n0, n1, bc, idle_run;
    bit got, seen, prev_busy;
    logic [31:0] d;
    bit grants[$];
    int gaps[$];

    for (int i = 0; i < 2; i++) begin
      ma[i] = '0; md[i] = '0; mw[i] = 1'b0; ml[i] = '0; mv[i] = 1'b0;
    end
    s_din = '0; s_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Read by m0, slave answers three cycles after the strobe first appears.
    ma[0] = 32'h40; mw[0] = 1'b0; ml[0] = 4'hF; md[0] = '0; mv[0] = 1'b1;
    s_din = 32'h1234_5678; sv = 0; n0 = 0; n1 = 0; d = '0;
    for (int i = 0; i < 10; i++) begin
      s_ready = (sv == 3);
      tick();
      if (o_svalid) sv++;
      if (o_rdy0) begin n0++; d = o_din0; mv[0] = 1'b0; end
      if (o_rdy1) n1++;
    end
    s_ready = 1'b0;
    chk("rd_pulses", n0, 1);
    chk("rd_data",   d, 32'h1234_5678);
    chk("rd_m1",     n1, 0);

    // Write by m1, slave port must carry m1's request verbatim.
    ma[1] = 32'h100; md[1] = 32'h0000_AABB; mw[1] = 1'b1; ml[1] = 4'b0011; mv[1] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_ready = (i == 4);
      tick();
      if (o_busy && !seen) begin
        seen = 1'b1;
        chk("wr_addr",  o_saddr, 32'h100);
        chk("wr_dout",  o_sdout, 32'h0000_AABB);
        chk("wr_wr",    32'(o_swr), 1);
        chk("wr_lane",  32'(o_slane), 32'h3);
        chk("wr_grant", 32'(o_grant), 1);
      end
      if (o_rdy1) mv[1] = 1'b0;
    end
    s_ready = 1'b0;
    chk("wr_seen", 32'(seen), 1);

    // Contention from reset: both masters keep requesting.
    @(negedge clk);
    do_reset();
    new_req(0); new_req(1);
    prev_busy = 1'b0; idle_run = 0;
    for (int i = 0; i < 60 && grants.size() < 4; i++) begin
      s_ready = 1'($urandom);
      s_din   = $urandom;
      tick();
      if (o_busy && !prev_busy) begin
        grants.push_back(o_grant);
        if (grants.size() > 1) gaps.push_back(idle_run);
        idle_run = 0;
      end else if (!o_busy) begin
        idle_run++;
      end
      prev_busy = o_busy;
      if (o_rdy0) new_req(0);
      if (o_rdy1) new_req(1);
    end
    chk("ct_count", grants.size(), 4);
    for (int k = 0; k < grants.size() && k < 4; k++) chk("ct_grant", 32'(grants[k]), 32'(k % 2));
    foreach (gaps[k]) chk("ct_gap", gaps[k], 1);
    mv[0] = 1'b0; mv[1] = 1'b0; s_ready = 1'b0;
    repeat (3) tick();

    // Slave never answers: timeout on the 16th busy cycle, late s_ready ignored.
    new_req(0); mw[0] = 1'b0; s_ready = 1'b0; bc = 0; got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      if (o_busy) bc++;
      if (o_rdy0) begin
        got = 1'b1;
        chk("to_cycle", bc, TMO);
        chk("to_err",   32'(o_tmo), 1);
        chk("to_din",   o_din0, ERR);
        mv[0] = 1'b0;
      end
    end
    chk("to_seen", 32'(got), 1);
    s_ready = 1'b1; n0 = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_rdy0 || o_rdy1 || o_tmo) n0++;
    end
    chk("to_late", n0, 0);
    s_ready = 1'b0;

    // s_ready lands on the timeout cycle: normal completion wins.
    new_req(0); s_din = 32'hCAFE_F00D; bc = 0; got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      s_ready = (bc == TMO - 1);
      tick();
      if (o_busy) bc++;
      if (o_rdy0) begin
        got = 1'b1;
        chk("tie_cycle", bc, TMO);
        chk("tie_err",   32'(o_tmo), 0);
        chk("tie_din",   o_din0, 32'hCAFE_F00D);
        mv[0] = 1'b0;
      end
    end
    chk("tie_seen", 32'(got), 1);
    s_ready = 1'b0;

    // Reset in the middle of an m1 transaction, then both request.
    new_req(1);
    tick();
    tick();
    chk("mid_busy", 32'(o_busy), 1);
    new_req(0);
    do_reset();
    tick();
    tick();
    chk("mid_pick_busy",  32'(o_busy), 1);
    chk("mid_pick_grant", 32'(o_grant), 0);

    // Random traffic with aborts, timeouts and one reset.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      for (int i = 0; i < 2; i++) begin
        if (mv[i] && e_rdy[i]) begin
          if ($urandom % 2 == 0) new_req(i);
          else mv[i] = 1'b0;
        end else if (mv[i] && ($urandom % 48 == 0)) begin
          mv[i] = 1'b0;
        end else if (!mv[i] && ($urandom % 3 == 0)) begin
          new_req(i);
        end
      end
      s_ready = ($urandom % 5 == 0);
      s_din   = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
